mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequential arbiter that shares the single off-chip memory port between the instruction cache and the data cache of the pipelined MIPS core. It sits between both cache miss-handling FSMs and the memory model. It grants the port to one requester at a time, holds the memory command stable until `mem_ready`, and returns `ready` and read data to the owner. The pipeline keeps stalling on each cache's own `stall` until its `ready` pulse arrives.

## Interface
- `ADDR_W`, default 28: line-address width in 16-byte lines.
- `DATA_W`, default 128: cache-line width in bits.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `i_read`, input, 1: I-cache line-refill request. Level; held until `i_ready`.
- `i_addr`, input, ADDR_W: I-cache line address.
- `i_rdata`, output, DATA_W: refill data for the I-cache.
- `i_ready`, output, 1: one-cycle completion pulse to the I-cache.
- `d_read`, input, 1: D-cache refill request. Level.
- `d_write`, input, 1: D-cache write-back request. Level.
- `d_addr`, input, ADDR_W: D-cache line address.
- `d_wdata`, input, DATA_W: D-cache write-back data.
- `d_rdata`, output, DATA_W: refill data for the D-cache.
- `d_ready`, output, 1: one-cycle completion pulse to the D-cache.
- `mem_read`, output, 1: memory read command. Registered.
- `mem_write`, output, 1: memory write command. Registered.
- `mem_addr`, output, ADDR_W: memory address. Registered.
- `mem_wdata`, output, DATA_W: memory write data. Registered.
- `mem_rdata`, input, DATA_W: memory read data, valid with `mem_ready`.
- `mem_ready`, input, 1: memory completion, high for one cycle.

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY, DONE.
- Priority flag `last_d` records which requester was granted most recently.
- **IDLE**
  - Only one request pending: grant it.
  - Both pending: grant the requester not granted last (round-robin).
  - Out of reset `last_d`=0, so the D-cache wins the first tie.
  - Granting loads `mem_*` registers from the owner and moves to I_BUSY or D_BUSY.
- **D-cache command**
  - `d_write`=1 issues a write and takes precedence over `d_read`.
  - `d_read` and `d_write` both high is a protocol violation. The block treats it as a write and the bench flags it.
  - Write: `mem_write`=1, `mem_wdata`=`d_wdata`.
  - Read: `mem_read`=1.
- **I_BUSY / D_BUSY**
  - `mem_*` registers hold constant regardless of input changes.
  - Requester changes while busy are ignored.
  - On `mem_ready`=1: owner `ready`=1 combinationally in that cycle, and the owner's `rdata`=`mem_rdata`.
  - In the same cycle: `mem_read`/`mem_write` are cleared at the clock edge, `last_d` is updated, and the FSM moves to DONE.
- **DONE**
  - Lasts exactly one cycle, then returns to IDLE.
  - No grant is made in DONE, because caches drop their request one cycle after `ready` (registered). This prevents a stale re-grant.
- **Read data outputs**
  - `i_rdata` and `d_rdata` are always driven with `mem_rdata`.
  - They are meaningful only while the matching `ready` is high.
- **`mem_ready` outside BUSY:** ignored. No `ready` is produced.
- **Reset (asynchronous, any time, including mid-transaction)**
  - State goes to IDLE and `last_d`=0.
  - `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, `i_ready`, `d_ready` all go to 0.
  - An in-flight memory transaction is abandoned. Its later `mem_ready` is ignored per the rule above.

## Timing
- Request in IDLE at edge N: `mem_*` command visible after edge N+1 (one-cycle grant latency).
- `ready` is coincident with `mem_ready`. DONE occupies the next cycle, and a new grant can issue the cycle after that.
- Back-to-back transaction turnaround: minimum 2 idle cycles between `mem_ready` and the next command.
- Worst-case wait for a requester: one full transaction of the other requester plus 3 cycles.

## Structure
- Shared package `mem_arb_pkg` holds:
  - state enum (IDLE=2'd0, I_BUSY=2'd1, D_BUSY=2'd2, DONE=2'd3);
  - owner encoding constants (OWN_I=1'b0, OWN_D=1'b1);
  - default ADDR_W and DATA_W.
- No sub-module needed. The FSM, priority flag and command registers fit in a single module.

## Test plan
- **Lone I-refill:** `i_read`=1, `i_addr`=28'h0000040; memory returns `mem_ready` 10 cycles later with data 128'hA5.. → `mem_read`=1, `mem_addr`=28'h0000040 one cycle after request. `i_ready` pulses in the `mem_ready` cycle with `i_rdata`=128'hA5... `d_ready` stays 0.
- **Simultaneous requests after reset:** `i_read`=1 and `d_read`=1 in the same cycle → D-cache granted first. The I-cache is granted two cycles after `d_ready`. A second simultaneous tie is then won by the I-cache.
- **D write-back then refill:** `d_write`=1, `d_addr`=28'h0000100, `d_wdata`=128'h1234.. → `mem_write`=1 with that data. After DONE, `d_read` with `d_addr`=28'h0000200 → `mem_read`=1, `mem_write`=0.
- **Stable command:** `d_addr` changes from 28'h10 to 28'h20 while D_BUSY → `mem_addr` stays 28'h10 until `mem_ready`.
- **Stale request in DONE:** owner holds `i_read` for one cycle after `i_ready` → no second `mem_read` is issued.
- **Reset mid-transaction:** `rst_n`=0 during D_BUSY → `mem_read`, `mem_write`, `d_ready` are 0 immediately, asynchronously. The later `mem_ready` produces no `ready`.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I-cache/D-cache memory port arbiter:
// FSM state encoding, owner encoding and default bus widths.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 28;
    localparam int unsigned DEF_DATA_W = 128;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t I_BUSY = 2'd1;
    localparam arb_state_t D_BUSY = 2'd2;
    localparam arb_state_t DONE   = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two cache miss ports and the shared memory port.
// master: the arbiter side; slave: caches plus memory model.
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refills and
// D-cache refills/write-backs; the memory command is registered and held until mem_ready.
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic clk,
    input  logic rst_n,
    mem_port_arbiter_if.master bus
);

    arb_state_t        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic d_req;
    logic grant_d;
    logic grant_i;

    // On a tie the D-cache wins unless it was the most recent owner.
    assign d_req   = bus.d_read | bus.d_write;
    assign grant_d = d_req & (~bus.i_read | (last_d_q == OWN_I));
    assign grant_i = bus.i_read & ~grant_d;

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = D_BUSY;
                    mem_write_d = bus.d_write;
                    mem_read_d  = ~bus.d_write;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                end else if (grant_i) begin
                    state_d     = I_BUSY;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = bus.i_addr;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus.mem_ready) begin
                    state_d     = DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    last_d_d    = (state_q == D_BUSY) ? OWN_D : OWN_I;
                end
            end
            // One dead cycle so a request still high from the owner is not re-granted.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_d_q    <= OWN_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign bus.i_ready = (state_q == I_BUSY) & bus.mem_ready;
    assign bus.d_ready = (state_q == D_BUSY) & bus.mem_ready;
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;

endmodule
